// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM (1-cycle registered read, byte write mask).
// Define RAM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed priority to port 0.
module ram_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              p0_req_i,
  input  logic              p0_lock_i,
  input  logic [3:0]        p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [31:0]       p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_lock_i,
  input  logic [3:0]        p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [31:0]       p1_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  input  logic [31:0]       ram_do_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;   // 1: port 1 was granted most recently
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;
  logic       rd_q, rd_d;

  logic lock0, lock1, exp0, exp1, g0, g1, gnt0, gnt1;

  always_comb begin
    // Owner keeps the port while it holds lock and has burst budget left.
    lock0 = (state_q == OWN0) && p0_req_i && p0_lock_i && (cnt_q < CNT_MAX);
    lock1 = (state_q == OWN1) && p1_req_i && p1_lock_i && (cnt_q < CNT_MAX);
    // Budget spent while still asking for lock: the waiting port takes over,
    // even under fixed priority.
    exp0  = (state_q == OWN0) && p0_req_i && p0_lock_i && (cnt_q == CNT_MAX) && p1_req_i;
    exp1  = (state_q == OWN1) && p1_req_i && p1_lock_i && (cnt_q == CNT_MAX) && p0_req_i;
    g0 = 1'b0;
    g1 = 1'b0;
    if (lock0 || exp1) begin
      g0 = 1'b1;
    end else if (lock1 || exp0) begin
      g1 = 1'b1;
    end else if (p0_req_i && p1_req_i) begin
`ifdef RAM_ARB_RR_EN
      g0 = last_q;
      g1 = ~last_q;
`else
      g0 = 1'b1;
`endif
    end else begin
      g0 = p0_req_i;
      g1 = p1_req_i;
    end
    gnt0 = g0 & rst_ni;
    gnt1 = g1 & rst_ni;
  end

  always_comb begin
    state_d = IDLE;
    if (gnt0)      state_d = OWN0;
    else if (gnt1) state_d = OWN1;

    cnt_d = 4'd0;
    if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1))
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;

    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;

    rv0_d = gnt0;
    rv1_d = gnt1;
    rd_d  = (gnt0 && p0_we_i == 4'd0) || (gnt1 && p1_we_i == 4'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    ram_en_o = gnt0 | gnt1;
    ram_we_o = 4'd0;
    ram_a_o  = '0;
    ram_di_o = 32'd0;
    if (gnt0) begin
      ram_we_o = p0_we_i;
      ram_a_o  = p0_addr_i;
      ram_di_o = p0_wdata_i;
    end else if (gnt1) begin
      ram_we_o = p1_we_i;
      ram_a_o  = p1_addr_i;
      ram_di_o = p1_wdata_i;
    end
  end

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign p0_rvalid_o = rv0_q;
  assign p1_rvalid_o = rv1_q;
  assign p0_rdata_o  = (rv0_q && rd_q) ? ram_do_i : 32'd0;
  assign p1_rdata_o  = (rv1_q && rd_q) ? ram_do_i : 32'd0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, corner sequences, and a
// randomized run against a run-length based reference model.
module tb_ram_port_arbiter;
  localparam int AW = 12;
  localparam int MB = 4;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst_n;
  logic p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0] p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic ram_en;
  logic [3:0] ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0] ram_di, ram_do;

  int n_tot = 0, n_pass = 0;

  ram_port_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(p0_req), .p0_lock_i(p0_lock), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_lock_i(p1_lock), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_di_o(ram_di), .ram_do_i(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro: registered read, byte-masked write
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'd0) ram_do <= mem[ram_a];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  typedef struct {
    logic r0, l0, r1, l1, e0, e1;
  } vec_t;
  vec_t tv [$];

  // reference model state
  int m_owner, m_run, m_last, pend_port;
  logic pend_rd;
  logic [31:0] pend_data;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A5A0000 ^ (i * 32'h00010101);
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'h11223344;
    ram_do = 0;

    // ---- reset: outputs quiet even with live requests
    idle_inputs();
    rst_n = 0;
    p0_req = 1; p0_we = 4'hF; p0_addr = 12'h123; p0_wdata = 32'h12345678;
    p1_req = 1; p1_addr = 12'h456;
    #2;
    chk("rst_g0", p0_gnt, 0);      chk("rst_g1", p1_gnt, 0);
    chk("rst_en", ram_en, 0);      chk("rst_we", ram_we, 0);
    chk("rst_a", ram_a, 0);        chk("rst_di", ram_di, 0);
    tick();
    chk("rst_rv0", p0_rvalid, 0);  chk("rst_rv1", p1_rvalid, 0);
    chk("rst_rd0", p0_rdata, 0);
    idle_inputs();
    tick();
    rst_n = 1;

    // ---- single read from port 0
    p0_req = 1; p0_addr = 12'h010; #1;
    chk("rd_g0", p0_gnt, 1);  chk("rd_g1", p1_gnt, 0);
    chk("rd_en", ram_en, 1);  chk("rd_a", ram_a, 12'h010); chk("rd_we", ram_we, 0);
    tick();
    idle_inputs();
    chk("rd_rv0", p0_rvalid, 1); chk("rd_data0", p0_rdata, 32'hDEADBEEF);
    chk("rd_rv1", p1_rvalid, 0); chk("rd_data1", p1_rdata, 0);
    tick();
    chk("rd_rv0_off", p0_rvalid, 0);

    // ---- table: contention, lock/burst expiry, owner drop, lock w/o req
    for (int i = 0; i < 4; i++)
      tv.push_back('{1, 0, 1, 0, (RR ? ((i % 2) == 0) : 1'b1), (RR ? ((i % 2) == 1) : 1'b0)});
    tv.push_back('{0, 0, 0, 0, 0, 0});
    for (int i = 0; i < MB; i++) tv.push_back('{1, 1, 1, 0, 1, 0});
    tv.push_back('{1, 1, 1, 0, 0, 1});   // burst spent, p1 takes over
    tv.push_back('{1, 1, 1, 0, 1, 0});
    tv.push_back('{0, 1, 1, 0, 0, 1});   // owner drops req
    tv.push_back('{1, 0, 1, 1, 0, 1});   // p1 locked
    tv.push_back('{1, 0, 0, 1, 1, 0});   // lock without req ignored
    tv.push_back('{0, 0, 0, 0, 0, 0});
    do_reset();
    p0_addr = 12'h0AA; p1_addr = 12'h0BB;
    foreach (tv[i]) begin
      p0_req = tv[i].r0; p0_lock = tv[i].l0; p1_req = tv[i].r1; p1_lock = tv[i].l1;
      #1;
      chk($sformatf("tbl%0d_g0", i), p0_gnt, tv[i].e0);
      chk($sformatf("tbl%0d_g1", i), p1_gnt, tv[i].e1);
      chk($sformatf("tbl%0d_a", i), ram_a, tv[i].e0 ? 12'h0AA : (tv[i].e1 ? 12'h0BB : 12'h000));
      tick();
      chk($sformatf("tbl%0d_rv0", i), p0_rvalid, tv[i].e0);
      chk($sformatf("tbl%0d_rv1", i), p1_rvalid, tv[i].e1);
    end

    // ---- masked write from p1, read back on p0
    idle_inputs();
    p1_req = 1; p1_we = 4'h3; p1_addr = 12'h020; p1_wdata = 32'hAABBCCDD; #1;
    chk("wr_g1", p1_gnt, 1); chk("wr_we", ram_we, 4'h3);
    chk("wr_di", ram_di, 32'hAABBCCDD); chk("wr_a", ram_a, 12'h020);
    tick();
    idle_inputs();
    chk("wr_rv1", p1_rvalid, 1); chk("wr_rd1", p1_rdata, 0);
    p0_req = 1; p0_addr = 12'h020; #1;
    chk("rb_g0", p0_gnt, 1);
    tick();
    idle_inputs();
    chk("rb_rv0", p0_rvalid, 1); chk("rb_data", p0_rdata, 32'h1122CCDD);
    tick();

    // ---- reset mid-burst with a response pending
    do_reset();
    p0_req = 1; p0_lock = 1; p0_addr = 12'h010; p0_we = 0;
    tick(); tick();
    chk("mb_rv0_pend", p0_rvalid, 1);
    rst_n = 0; #1;
    chk("mb_g0", p0_gnt, 0);   chk("mb_rv0", p0_rvalid, 0); chk("mb_rd0", p0_rdata, 0);
    chk("mb_en", ram_en, 0);   chk("mb_a", ram_a, 0);       chk("mb_we", ram_we, 0);
    tick();
    chk("mb_rv0_hold", p0_rvalid, 0);
    idle_inputs();
    rst_n = 1;
    p1_req = 1; p1_lock = 1; p1_addr = 12'h0BB; #1;
    chk("mb_after_g1", p1_gnt, 1);
    tick();
    p0_req = 1;
    for (int i = 1; i <= MB; i++) begin
      #1;
      chk($sformatf("mb_burst%0d_g1", i), p1_gnt, i < MB);
      chk($sformatf("mb_burst%0d_g0", i), p0_gnt, i == MB);
      tick();
    end

    // ---- randomized run against the reference model
    do_reset();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
    m_owner = -1; m_run = 0; m_last = 1; pend_port = -1; pend_rd = 0; pend_data = 0;
    for (int c = 0; c < 400; c++) begin
      int eg;
      logic [3:0] w;
      logic [AW-1:0] a;
      p0_req = ($urandom_range(0, 9) < 6); p0_lock = $urandom_range(0, 1);
      p1_req = ($urandom_range(0, 9) < 6); p1_lock = $urandom_range(0, 1);
      p0_we = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
      p1_we = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
      p0_addr = AW'($urandom_range(0, 15)); p1_addr = AW'($urandom_range(0, 15));
      p0_wdata = $urandom; p1_wdata = $urandom;
      #1;
      begin
        logic rq [2];
        logic lk [2];
        rq[0] = p0_req; rq[1] = p1_req; lk[0] = p0_lock; lk[1] = p1_lock;
        if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && m_run < MB) eg = m_owner;
        else if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && rq[1 - m_owner]) eg = 1 - m_owner;
        else if (rq[0] && rq[1]) eg = RR ? 1 - m_last : 0;
        else if (rq[0]) eg = 0;
        else if (rq[1]) eg = 1;
        else eg = -1;
      end
      chk("rnd_g0", p0_gnt, eg == 0);
      chk("rnd_g1", p1_gnt, eg == 1);
      chk("rnd_en", ram_en, eg >= 0);
      w = (eg == 0) ? p0_we : (eg == 1) ? p1_we : 4'd0;
      a = (eg == 1) ? p1_addr : p0_addr;
      chk("rnd_we", ram_we, w);
      if (eg >= 0) chk("rnd_a", ram_a, a);
      pend_port = eg;
      pend_rd = (w == 4'd0);
      pend_data = ref_mem[a];
      if (eg >= 0) for (int b = 0; b < 4; b++)
        if (w[b]) ref_mem[a][8*b +: 8] = (eg == 0) ? p0_wdata[8*b +: 8] : p1_wdata[8*b +: 8];
      if (eg < 0) begin m_owner = -1; m_run = 0; end
      else begin
        m_run = (eg == m_owner) ? m_run + 1 : 1;
        m_owner = eg; m_last = eg;
      end
      tick();
      chk("rnd_rv0", p0_rvalid, pend_port == 0);
      chk("rnd_rv1", p1_rvalid, pend_port == 1);
      chk("rnd_rd0", p0_rdata, (pend_port == 0 && pend_rd) ? pend_data : 32'd0);
      chk("rnd_rd1", p1_rdata, (pend_port == 1 && pend_rd) ? pend_data : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width to the RAM macro.
REQ-002 SHALL have parameter MAX_BURST, default 4, max consecutive locked grants to one port, range 1..15.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pN_req_i  input  1  port N (N=0,1) access request.
REQ-006 SHALL have port pN_lock_i  input  1  port N requests to keep ownership next cycle.
REQ-007 SHALL have port pN_we_i  input  4  port N byte write mask; 0 = read.
REQ-008 SHALL have port pN_addr_i  input  ADDR_W  port N word address.
REQ-009 SHALL have port pN_wdata_i  input  32  port N write data.
REQ-010 SHALL have port pN_gnt_o  output  1  port N request accepted this cycle.
REQ-011 SHALL have port pN_rvalid_o  output  1  port N response valid.
REQ-012 SHALL have port pN_rdata_o  output  32  port N read data.
REQ-013 SHALL have ports ram_en_o (1), ram_we_o (4), ram_a_o (ADDR_W), ram_di_o (32) as outputs and ram_do_i (32) as input, to a single-port RAM with 1-cycle registered read and per-byte write mask.

Function
REQ-014 SHALL grant at most one port per cycle; gnt combinational from req and state, same cycle.
REQ-015 SHALL drive ram_en_o=1 and ram_we_o/ram_a_o/ram_di_o from the granted port; no grant -> ram_en_o=0, ram_we_o=0.
REQ-016 SHALL assert pN_rvalid_o exactly one cycle after pN_gnt_o, for reads and writes; responses cannot be stalled.
REQ-017 SHALL drive pN_rdata_o = ram_do_i when pN_rvalid_o=1 and a read; otherwise 0.
REQ-018 SHALL support back-to-back grants every cycle, to the same or alternating ports.
REQ-019 SHALL implement FSM IDLE, OWN0, OWN1 = owner of last cycle's grant; IDLE when no grant.
REQ-020 In OWNk with pk_req_i=1, pk_lock_i=1, burst_cnt<MAX_BURST-1: SHALL grant port k regardless of other port.
REQ-021 Otherwise SHALL arbitrate per REQ-029/030; winner sets OWNwinner, none -> IDLE.
REQ-022 burst_cnt SHALL increment on a grant to the current owner, reset to 0 on owner change or IDLE, saturate at MAX_BURST-1.
REQ-023 Lock expiry (burst_cnt=MAX_BURST-1) with other port requesting SHALL hand the grant to the other port next cycle.
REQ-024 pN_lock_i without pN_req_i SHALL be ignored.
REQ-025 Owner dropping req while the other requests SHALL grant the other the same cycle.

Reset
REQ-026 On rst_ni=0 SHALL immediately enter IDLE, burst_cnt=0, last-grant=port 1, rvalid=0.
REQ-027 During reset all outputs SHALL be 0: gnt, rvalid, rdata, ram_en_o, ram_we_o, ram_a_o, ram_di_o.
REQ-028 A grant in the cycle reset asserts SHALL produce no rvalid.

Configuration
REQ-029 With RAM_ARB_RR_EN defined: simultaneous non-locked requests SHALL go to the port not granted most recently.
REQ-030 Without RAM_ARB_RR_EN: port 0 SHALL win simultaneous non-locked requests; lock/burst rules unchanged.

Verification
REQ-031 p0 read addr 0x010 (RAM 0x010=0xDEADBEEF), p1 idle -> p0_gnt_o=1 cycle 0; p0_rvalid_o=1, p0_rdata_o=0xDEADBEEF cycle 1; p1 outputs 0.
REQ-032 Both request, no lock, 4 cycles -> RR: grants p0,p1,p0,p1; fixed: p0 x4, p1_gnt_o=0.
REQ-033 p0 lock+req, p1 req, MAX_BURST=4 -> p0 granted 4 cycles, p1 cycle 5.
REQ-034 p1 write we=0x3 data 0xAABBCCDD addr 0x020 over 0x11223344, then p0 read 0x020 -> ram_we_o=0x3; read returns 0x1122CCDD.
REQ-035 rst_ni low mid-burst with rvalid pending -> outputs 0 that cycle; after release p1 single request granted, burst_cnt=0.
REQ-036 p0 owner drops req while p1 requests -> p1_gnt_o=1 same cycle; ram_a_o = p1_addr_i.
